framebuffer_window_ctrl: RTL
============================

FRAMEBUFFER_WINDOW_CTRL -- requirements
Module: framebuffer_window_ctrl

Interface
REQ-001 SHALL have parameter H_RES, default 480, panel width in pixels.
REQ-002 SHALL have parameter V_RES, default 320, panel height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 18, framebuffer address width; H_RES*V_RES <= 2^ADDR_W.
REQ-004 SHALL have port i_clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_command  in  8  DCS command byte, valid with i_command_latch.
REQ-007 SHALL have port i_command_latch  in  1  one-cycle command strobe.
REQ-008 SHALL have port i_param  in  8  command parameter byte, valid with i_param_latch.
REQ-009 SHALL have port i_param_latch  in  1  one-cycle parameter strobe.
REQ-010 SHALL have port i_rgb565  in  16  pixel data, valid with i_rgb565_latch.
REQ-011 SHALL have port i_rgb565_latch  in  1  one-cycle pixel strobe.
REQ-012 SHALL have port o_write_address  out  ADDR_W  framebuffer write address.
REQ-013 SHALL have port o_write_data  out  16  framebuffer write data.
REQ-014 SHALL have port o_write_enable  out  1  one-cycle write strobe.
REQ-015 SHALL have port o_param_err  out  1  one-cycle pulse on rejected window.

Function
REQ-016 SHALL implement states IDLE, CASET_P, PASET_P, WRITE.
REQ-017 SHALL, on command 0x2A, enter CASET_P with param counter cleared; 4 params = SC[15:8], SC[7:0], EC[15:8], EC[7:0].
REQ-018 SHALL, on command 0x2B, enter PASET_P likewise; 4 params = SP hi/lo, EP hi/lo.
REQ-019 SHALL update window registers only in the cycle after the 4th param, then return to IDLE; further params ignored.
REQ-020 SHALL discard a partial (<4 param) CASET/PASET when any command arrives; window registers unchanged.
REQ-021 SHALL, on 0x2C (RAMWR), load pointer (col,row)=(SC,SP) and enter WRITE.
REQ-022 SHALL, on 0x3C (RAMWRC), keep current pointer and enter WRITE.
REQ-023 SHALL, on any other command, enter IDLE.
REQ-024 SHALL ignore i_param_latch in IDLE and WRITE, and i_rgb565_latch outside WRITE.
REQ-025 SHALL, on pixel strobe in WRITE, assert o_write_enable exactly 1 cycle later, with o_write_data = sampled i_rgb565 and o_write_address = row*H_RES + col (pre-advance pointer).
REQ-026 SHALL advance pointer per pixel: col<EC -> col+1; col==EC -> col=SC and row = (row==EP) ? SP : row+1 (wrap to window start).
REQ-027 SHALL give command strobe priority over a same-cycle pixel strobe; that pixel dropped, no write.
REQ-028 SHALL accept back-to-back pixel strobes every cycle (one write per cycle).
REQ-029 SHALL hold o_write_address and o_write_data between writes; o_write_enable low otherwise.

Reset
REQ-030 SHALL, while i_rst high at clock edge, set state IDLE, param counter 0, SC=0, EC=H_RES-1, SP=0, EP=V_RES-1, pointer (0,0).
REQ-031 SHALL reset o_write_address=0, o_write_data=16'h0000, o_write_enable=0, o_param_err=0.
REQ-032 SHALL discard any in-flight pixel or partial parameter sequence on reset; no write in the cycle after reset.

Configuration
REQ-033 SHALL, with macro FB_WINDOW_PARAM_CHECK_EN defined, reject a completed CASET if SC>EC or EC>=H_RES (PASET: SP>EP or EP>=V_RES): registers unchanged, o_param_err pulses 1 cycle.
REQ-034 SHALL, without FB_WINDOW_PARAM_CHECK_EN, accept all values unchecked (low ADDR_W bits of address used) and tie o_param_err to 0.

Verification
REQ-035 SHALL verify: reset, 0x2C, 3 pixels 0xF800,0x07E0,0x001F -> writes at addr 0,1,2 with that data, each 1 cycle after strobe.
REQ-036 SHALL verify: CASET 10..12, PASET 5..6, 0x2C, 7 pixels -> addrs 2410,2411,2412,2890,2891,2892,2410.
REQ-037 SHALL verify: CASET with 2 params then 0x2C -> window still full, first write addr 0.
REQ-038 SHALL verify: after 4 pixels in window of REQ-036, 0x3C, 1 pixel -> addr 2891; same-cycle 0x2C+pixel -> no write.
REQ-039 SHALL verify (FB_WINDOW_PARAM_CHECK_EN): CASET 0..480 -> o_param_err 1 pulse, window unchanged; without macro o_param_err stays 0.
REQ-040 SHALL verify: i_rst asserted mid-WRITE with pixel strobe -> no write next cycle, all outputs 0, window back to full.

Source files
------------

// File: rtl/framebuffer_window_ctrl.sv
// framebuffer_window_ctrl: DCS-style window controller for a panel framebuffer.
// CASET/PASET set the column/page window, RAMWR/RAMWRC stream RGB565 pixels
// into the window, which wraps back to its start once filled.
// Optional build macro: FB_WINDOW_PARAM_CHECK_EN rejects out-of-range windows
// and pulses o_param_err; when undefined all windows are accepted as given.
module framebuffer_window_ctrl #(
    parameter int H_RES  = 480,
    parameter int V_RES  = 320,
    parameter int ADDR_W = 18
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_command,
    input  logic              i_command_latch,
    input  logic [7:0]        i_param,
    input  logic              i_param_latch,
    input  logic [15:0]       i_rgb565,
    input  logic              i_rgb565_latch,
    output logic [ADDR_W-1:0] o_write_address,
    output logic [15:0]       o_write_data,
    output logic              o_write_enable,
    output logic              o_param_err
);

    typedef enum logic [1:0] {IDLE, CASET_P, PASET_P, WRITE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  pcnt;
    logic [31:0] pbuf;           // {start[15:0], end[15:0]} after 4 params
    logic [15:0] sc, ec, sp, ep;
    logic [15:0] col, row;
    logic        seq_done_c, seq_done_p;
    logic        win_ok_c, win_ok_p;
    logic        commit_c, commit_p, pix_ok;
    logic [15:0] eff_sc, eff_sp;

`ifdef FB_WINDOW_PARAM_CHECK_EN
    assign win_ok_c = (pbuf[31:16] <= pbuf[15:0]) && (pbuf[15:0] < 16'(H_RES));
    assign win_ok_p = (pbuf[31:16] <= pbuf[15:0]) && (pbuf[15:0] < 16'(V_RES));
`else
    assign win_ok_c = 1'b1;
    assign win_ok_p = 1'b1;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: any command wins; a finished param sequence falls back to IDLE
    always_comb begin
        state_nxt = state;
        if (i_command_latch) begin
            case (i_command)
                8'h2A:        state_nxt = CASET_P;
                8'h2B:        state_nxt = PASET_P;
                8'h2C, 8'h3C: state_nxt = WRITE;
                default:      state_nxt = IDLE;
            endcase
        end else if (seq_done_c || seq_done_p) begin
            state_nxt = IDLE;
        end
    end

    // FSM outputs: window commit strobes and pixel acceptance
    always_comb begin
        seq_done_c = (state == CASET_P) && (pcnt == 3'd4);
        seq_done_p = (state == PASET_P) && (pcnt == 3'd4);
        commit_c   = seq_done_c && win_ok_c;
        commit_p   = seq_done_p && win_ok_p;
        pix_ok     = (state == WRITE) && i_rgb565_latch && !i_command_latch;
    end

    // RAMWR issued in a commit cycle must see the freshly committed start
    assign eff_sc = commit_c ? pbuf[31:16] : sc;
    assign eff_sp = commit_p ? pbuf[31:16] : sp;

    // Parameter collection; any command restarts the count
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pcnt <= 3'd0;
            pbuf <= 32'd0;
        end else if (i_command_latch) begin
            pcnt <= 3'd0;
        end else if ((state == CASET_P || state == PASET_P) && i_param_latch && pcnt < 3'd4) begin
            pbuf <= {pbuf[23:0], i_param};
            pcnt <= pcnt + 3'd1;
        end
    end

    // Window registers, updated only by a completed (and accepted) sequence
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sc <= 16'd0;
            ec <= 16'(H_RES - 1);
            sp <= 16'd0;
            ep <= 16'(V_RES - 1);
        end else begin
            if (commit_c) {sc, ec} <= pbuf;
            if (commit_p) {sp, ep} <= pbuf;
        end
    end

    // Write pointer: reload on RAMWR, raster-advance inside the window per pixel
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col <= 16'd0;
            row <= 16'd0;
        end else if (i_command_latch && i_command == 8'h2C) begin
            col <= eff_sc;
            row <= eff_sp;
        end else if (pix_ok) begin
            if (col < ec) begin
                col <= col + 16'd1;
            end else begin
                col <= sc;
                row <= (row == ep) ? sp : row + 16'd1;
            end
        end
    end

    // Framebuffer write port, one cycle behind the pixel strobe
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_write_enable  <= 1'b0;
            o_write_address <= '0;
            o_write_data    <= 16'h0000;
        end else begin
            o_write_enable <= pix_ok;
            if (pix_ok) begin
                o_write_address <= ADDR_W'(32'(row) * 32'(H_RES) + 32'(col));
                o_write_data    <= i_rgb565;
            end
        end
    end

`ifdef FB_WINDOW_PARAM_CHECK_EN
    // Rejected window: one-cycle error pulse in the cycle after the commit slot
    always_ff @(posedge i_clk) begin
        if (i_rst) o_param_err <= 1'b0;
        else       o_param_err <= (seq_done_c && !win_ok_c) || (seq_done_p && !win_ok_p);
    end
`else
    assign o_param_err = 1'b0;
`endif

endmodule
